// File: rtl/lsu_ctrl_if.sv
// Core/memory bundle for the load/store initiator.
//   req_*  : core request channel (valid/ready handshake, we, funct3, byte address, store data)
//   rsp_*  : one-cycle response pulse with load data and fault code
//   mem_*  : word-indexed data memory port (lane strobes, load code, ack, read data)
// slave  : view taken by lsu_ctrl
// master : view taken by the core/memory side (testbench)
interface lsu_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic [1:0]        rsp_fault;

  logic [31:0]       mem_addr;
  logic [3:0]        mem_wmem;
  logic [4:0]        mem_rmem;
  logic [31:0]       mem_store_data;
  logic              mem_ack;
  logic [31:0]       mem_load_data;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_load_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault,
           mem_addr, mem_wmem, mem_rmem, mem_store_data
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_load_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
           mem_addr, mem_wmem, mem_rmem, mem_store_data
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store initiator between the execute stage and the word-indexed data memory.
// Accepts one request at a time, decodes funct3/offset into lane strobes and a load
// code, drives the memory until ack (or timeout) and returns a one-cycle response.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : lsu_ctrl_if.slave (request, response and memory channels)
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  lsu_ctrl_if.slave   bus
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] FLT_OK      = 2'b00;
  localparam logic [1:0] FLT_MISALGN = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT = 2'b10;
  localparam logic [1:0] FLT_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state_q;
  logic             rdy_q;
  logic             we_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      mem_addr_q;
  logic [31:0]      mem_store_data_q;
  logic [3:0]       mem_wmem_q;
  logic [4:0]       mem_rmem_q;
  logic             rsp_valid_q;
  logic [31:0]      rsp_rdata_q;
  logic [1:0]       rsp_fault_q;

  logic [1:0]       off;
  logic [2:0]       f3;
  logic [3:0]       dec_lanes;
  logic [1:0]       dec_fault;
  logic             dec_sign;
  logic             dec_illegal;

  // Request decode: byte lanes, sign-extend flag and fault code (illegal beats misaligned).
  always_comb begin
    off       = bus.req_addr[1:0];
    f3        = bus.req_funct3;
    dec_lanes = 4'b0000;
    dec_fault = FLT_OK;
    dec_sign  = ~f3[2] & (f3[1:0] != 2'b10);
    case (f3[1:0])
      2'b00: dec_lanes = 4'b0001 << off;
      2'b01: begin
        if (off[0]) dec_fault = FLT_MISALGN;
        else        dec_lanes = off[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        if (off != 2'b00) dec_fault = FLT_MISALGN;
        else              dec_lanes = 4'b1111;
      end
      default: dec_fault = FLT_ILLEGAL;
    endcase
    dec_illegal = bus.req_we ? (f3[2] | (f3 == 3'b011))
                             : ((f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111));
    if (dec_illegal) dec_fault = FLT_ILLEGAL;
  end

  // Ready only in IDLE, and only once the first edge after reset release has passed.
  assign bus.req_ready      = rdy_q && (state_q == IDLE);
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_rdata      = rsp_rdata_q;
  assign bus.rsp_fault      = rsp_fault_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_wmem       = mem_wmem_q;
  assign bus.mem_rmem       = mem_rmem_q;
  assign bus.mem_store_data = mem_store_data_q;

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      rdy_q            <= 1'b0;
      we_q             <= 1'b0;
      cnt_q            <= '0;
      mem_addr_q       <= '0;
      mem_store_data_q <= '0;
      mem_wmem_q       <= '0;
      mem_rmem_q       <= '0;
      rsp_valid_q      <= 1'b0;
      rsp_rdata_q      <= '0;
      rsp_fault_q      <= FLT_OK;
    end else begin
      rdy_q       <= 1'b1;
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            if (dec_fault != FLT_OK) begin
              // Faulted requests never touch the memory.
              rsp_valid_q <= 1'b1;
              rsp_fault_q <= dec_fault;
              rsp_rdata_q <= '0;
              state_q     <= RESP;
            end else begin
              mem_addr_q       <= 32'(bus.req_addr[ADDR_W-1:2]);
              mem_store_data_q <= bus.req_wdata;
              we_q             <= bus.req_we;
              cnt_q            <= '0;
              if (bus.req_we) mem_wmem_q <= dec_lanes;
              else            mem_rmem_q <= {dec_sign, dec_lanes};
              state_q          <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (bus.mem_ack) begin
            // Ack on the last allowed cycle still counts as success.
            mem_wmem_q  <= '0;
            mem_rmem_q  <= '0;
            rsp_valid_q <= 1'b1;
            rsp_fault_q <= FLT_OK;
            rsp_rdata_q <= we_q ? 32'd0 : bus.mem_load_data;
            state_q     <= RESP;
          end else if (cnt_q == CNT_LAST) begin
            mem_wmem_q  <= '0;
            mem_rmem_q  <= '0;
            rsp_valid_q <= 1'b1;
            rsp_fault_q <= FLT_TIMEOUT;
            rsp_rdata_q <= '0;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store initiator that sits between the core execute stage and the word-indexed data memory. It takes one load or store request at a time from the core, decodes funct3 and the byte offset into the memory's byte-lane strobes (wmem) and load-select code (rmem), and drives the memory. It then waits for the memory acknowledge and returns the result, or a fault code, to the core.

Parameters:
TIMEOUT_CYCLES, 16, max cycles spent in ACCESS without mem_ack before a timeout fault; must be >=1.
ADDR_W, 32, width of the core byte address.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  core request valid
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V funct3 of the load/store
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned as in rs2
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  load result, extension already applied by memory; 0 for stores and faults
rsp_fault  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal funct3
mem_addr  out  32  word index = {2'b0, req_addr[31:2]}
mem_wmem  out  4  store byte-lane strobe
mem_rmem  out  5  load code: bit4 = sign-extend, bits3:0 = byte lanes
mem_store_data  out  32  store data, passed unshifted (the memory positions the bytes)
mem_ack  in  1  memory completed the access this cycle (tie high for the single-cycle data memory)
mem_load_data  in  32  memory read data, valid while mem_ack=1

Behaviour:
- States: IDLE, ACCESS, RESP. All outputs are registered except req_ready.
- Reset (async, rst_n=0):
  - state goes to IDLE.
  - mem_wmem, mem_rmem, mem_addr, mem_store_data, rsp_valid, rsp_rdata, rsp_fault all 0; timeout counter 0.
  - req_ready is 0 while rst_n=0. It equals (state==IDLE) gated by a ready flag that is set on the first clk edge after reset release.
- Reset during ACCESS aborts the access. Strobes drop immediately and no response is issued.
- Decode, with off = req_addr[1:0]:
  - Byte (funct3 x00): lanes = 1<<off.
  - Half (x01): off=0 gives 0011, off=2 gives 1100, off 1/3 is misaligned.
  - Word (010): off=0 gives 1111, otherwise misaligned.
- Sign bit:
  - rmem[4]=1 for LB(000) and LH(001).
  - 0 for LBU(100), LHU(101) and LW(010, rmem=01111).
- Illegal funct3:
  - Loads: 011, 110, 111.
  - Stores: any funct3 not in {000, 001, 010}.
  - Illegal takes priority over misaligned.
- IDLE, on req_valid && req_ready:
  - If a fault is decoded: no mem strobes; go to RESP with the fault code.
  - Otherwise load mem_addr, mem_store_data and either mem_wmem (store) or mem_rmem (load) at that edge; the other strobe stays 0. Go to ACCESS and clear the counter.
- ACCESS:
  - Strobes are held stable.
  - On mem_ack: capture mem_load_data into rsp_rdata (loads; 0 for stores), fault=00, clear strobes at the same edge, go to RESP. This gives exactly one write edge when mem_ack is tied high.
  - Without ack: the counter increments. When counter == TIMEOUT_CYCLES-1 and still no ack, clear strobes, set fault=10, rsp_rdata=0, go to RESP.
  - mem_ack arriving on the final timeout cycle counts as success.
- RESP:
  - rsp_valid=1 for exactly one cycle; no backpressure.
  - Next state is IDLE; rsp_valid returns to 0.
  - rsp_rdata and rsp_fault hold their value until the next response.
- Latency with mem_ack=1:
  - Accept at edge N, ACCESS during cycle N+1, rsp_valid during cycle N+2.
  - Fault path: rsp_valid during cycle N+1.
- Throughput: one request per 3 cycles. req_ready=0 in ACCESS and RESP.
- req_valid while not ready is ignored; the request must be held by the core.

Test Plan:
1. SW: addr=0x0000_0010, wdata=0xDEADBEEF, mem_ack=1 -> mem_addr=0x4, mem_wmem=1111 for exactly one cycle, mem_rmem=0; rsp_valid 2 cycles after accept, fault=00, rdata=0.
2. LB: addr=0x13, mem_load_data=0xFFFFFF80 -> mem_rmem=11000, mem_addr=0x4; rsp_rdata=0xFFFFFF80, fault=00. Repeat as LHU at addr 0x12 -> mem_rmem=01100.
3. LH at 0x11 -> no strobes ever asserted; rsp_valid 1 cycle after accept; fault=01. SW at 0x2 -> fault=01. Load funct3=011 at 0x1 -> fault=11 (illegal wins).
4. LW, mem_ack held 0, TIMEOUT_CYCLES=16 -> mem_rmem=01111 for exactly 16 cycles, then 0; rsp fault=10, rdata=0. Second run with ack on the 16th cycle -> fault=00.
5. Assert rst_n=0 mid-ACCESS with ack held low -> strobes 0 immediately, no rsp_valid; req_ready=0 until the first edge after release, then 1.
6. Back-to-back SB 0x21 then LBU 0x21, core holds req_valid -> second accept exactly 3 cycles after the first; SB wmem=0010; LBU rmem=00010.
